// File: rtl/dbg_run_ctrl.sv
// Debug run-control sequencer: halt / step-N / resume / core-reset commands,
// breakpoint halting, and the registered clock-enable and core-reset outputs.
module dbg_run_ctrl #(
  parameter int unsigned STEP_W     = 16,
  parameter int unsigned RST_CYCLES = 8
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_count,
  input  logic              bkpt_hit,
  output logic              clk_en,
  output logic              dm_reset,
  output logic              halted,
  output logic [STEP_W-1:0] steps_left,
  output logic              bkpt_flag,
  output logic              done
);

  localparam int unsigned CntW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(RST_CYCLES - 1);

  localparam logic [1:0] OpHalt   = 2'b00;
  localparam logic [1:0] OpStep   = 2'b01;
  localparam logic [1:0] OpResume = 2'b10;
  localparam logic [1:0] OpReset  = 2'b11;

  typedef enum logic [1:0] {StRun, StHalt, StStep, StRstHold} state_e;

  state_e            state_q, state_d;
  logic              ret_halt_q, ret_halt_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic              flag_q, flag_d;
  logic              done_q, done_d;
  logic              clk_en_q, clk_en_d;
  logic              dm_reset_q, dm_reset_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              accept;

  assign cmd_ready  = (state_q == StRun) || (state_q == StHalt);
  assign accept     = cmd_valid && cmd_ready;
  assign clk_en     = clk_en_q;
  assign dm_reset   = dm_reset_q;
  assign halted     = (state_q == StHalt);
  assign steps_left = steps_q;
  assign bkpt_flag  = flag_q;
  assign done       = done_q;

  // Next-state and registered-output logic for the run-control sequencer.
  always_comb begin
    state_d    = state_q;
    ret_halt_d = ret_halt_q;
    steps_d    = steps_q;
    flag_d     = flag_q;
    done_d     = 1'b0;
    cnt_d      = cnt_q;

    unique case (state_q)
      StRun: begin
        // Breakpoint wins over a same-edge command, which is still consumed.
        if (bkpt_hit) begin
          state_d = StHalt;
          flag_d  = 1'b1;
          done_d  = 1'b1;
        end else if (accept) begin
          case (cmd_op)
            OpHalt: state_d = StHalt;
            OpReset: begin
              state_d    = StRstHold;
              ret_halt_d = 1'b0;
              cnt_d      = '0;
            end
            default: ;
          endcase
        end
      end
      StHalt: begin
        if (accept) begin
          case (cmd_op)
            OpStep: begin
              state_d = StStep;
              steps_d = (cmd_count == '0) ? STEP_W'(1) : cmd_count;
              flag_d  = 1'b0;
            end
            OpResume: begin
              state_d = StRun;
              flag_d  = 1'b0;
            end
            OpReset: begin
              state_d    = StRstHold;
              ret_halt_d = 1'b1;
              cnt_d      = '0;
              flag_d     = 1'b0;
            end
            default: ;
          endcase
        end
      end
      StStep: begin
        // The final-count edge is a normal completion even with bkpt_hit set.
        if (steps_q <= STEP_W'(1)) begin
          state_d = StHalt;
          steps_d = '0;
          done_d  = 1'b1;
        end else if (bkpt_hit) begin
          state_d = StHalt;
          flag_d  = 1'b1;
          done_d  = 1'b1;
        end else begin
          steps_d = steps_q - STEP_W'(1);
        end
      end
      StRstHold: begin
        if (cnt_q == CntLast) begin
          state_d = ret_halt_q ? StHalt : StRun;
          steps_d = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StRun;
    endcase

    clk_en_d   = (state_d != StHalt);
    dm_reset_d = (state_d == StRstHold);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q    <= StRun;
      ret_halt_q <= 1'b0;
      steps_q    <= '0;
      flag_q     <= 1'b0;
      done_q     <= 1'b0;
      clk_en_q   <= 1'b1;
      dm_reset_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ret_halt_q <= ret_halt_d;
      steps_q    <= steps_d;
      flag_q     <= flag_d;
      done_q     <= done_d;
      clk_en_q   <= clk_en_d;
      dm_reset_q <= dm_reset_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dbg_run_ctrl.sv
// Scoreboard bench for dbg_run_ctrl: a transaction-level model expands each
// command into its expected per-cycle outputs; a monitor compares every cycle.
module tb_dbg_run_ctrl;

  localparam int unsigned StepW     = 16;
  localparam int unsigned RstCycles = 8;

  localparam logic [1:0] OpHalt   = 2'b00;
  localparam logic [1:0] OpStep   = 2'b01;
  localparam logic [1:0] OpResume = 2'b10;
  localparam logic [1:0] OpReset  = 2'b11;

  logic             sys_clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [StepW-1:0] cmd_count;
  logic             bkpt_hit;
  logic             clk_en;
  logic             dm_reset;
  logic             halted;
  logic [StepW-1:0] steps_left;
  logic             bkpt_flag;
  logic             done;

  dbg_run_ctrl #(
    .STEP_W    (StepW),
    .RST_CYCLES(RstCycles)
  ) dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_count (cmd_count),
    .bkpt_hit  (bkpt_hit),
    .clk_en    (clk_en),
    .dm_reset  (dm_reset),
    .halted    (halted),
    .steps_left(steps_left),
    .bkpt_flag (bkpt_flag),
    .done      (done)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic             clk_en;
    logic             dm_reset;
    logic             halted;
    logic [StepW-1:0] steps;
    logic             flag;
    logic             done;
    logic             ready;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    passes = 0;

  // Abstract model of the core as seen by the debugger.
  bit               m_halt;
  bit               m_flag;
  logic [StepW-1:0] m_steps;

  function automatic obs_t settled();
    obs_t e;
    e.clk_en   = !m_halt;
    e.dm_reset = 1'b0;
    e.halted   = m_halt;
    e.steps    = m_steps;
    e.flag     = m_flag;
    e.done     = 1'b0;
    e.ready    = 1'b1;
    return e;
  endfunction

  task automatic tick(input logic v, input logic [1:0] op, input logic [StepW-1:0] cnt,
                      input logic bk, input logic rs, input obs_t e, input string tag);
    cmd_valid = v;
    cmd_op    = op;
    cmd_count = cnt;
    bkpt_hit  = bk;
    reset     = rs;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge sys_clk);
    #1;
  endtask

  // Random command lines; used while the DUT cannot accept.
  task automatic junk_tick(input logic bk, input logic rs, input obs_t e, input string tag);
    tick(1'($urandom % 2), 2'($urandom), 16'($urandom), bk, rs, e, tag);
  endtask

  task automatic reset_tick();
    obs_t e;
    m_halt  = 1'b0;
    m_flag  = 1'b0;
    m_steps = '0;
    e = settled();
    junk_tick(1'($urandom % 2), 1'b1, e, "reset");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1'b0, 2'($urandom), 16'($urandom), m_halt ? 1'($urandom % 2) : 1'b0, 1'b0,
           settled(), "idle");
    end
  endtask

  // STEP from halt; b = edge index of a breakpoint pulse (0: none), abort = edge to reset at.
  task automatic step_seq(input logic [StepW-1:0] cnt, input logic bk, input int b,
                          input int abort);
    obs_t e;
    int   n;
    n = (cnt == '0) ? 1 : int'(cnt);
    m_flag = 1'b0;
    e = settled();
    e.clk_en = 1'b1;
    e.halted = 1'b0;
    e.ready  = 1'b0;
    e.steps  = 16'(n);
    tick(1'b1, OpStep, cnt, bk, 1'b0, e, "step_go");
    for (int k = 1; k <= n; k++) begin
      if (k == abort) begin
        reset_tick();
        return;
      end
      if (k == n) begin
        m_steps = '0;
        m_halt  = 1'b1;
        e = settled();
        e.done = 1'b1;
        junk_tick(k == b, 1'b0, e, "step_end");
        return;
      end
      if (k == b) begin
        m_steps = 16'(n - k + 1);
        m_halt  = 1'b1;
        m_flag  = 1'b1;
        e = settled();
        e.done = 1'b1;
        junk_tick(1'b1, 1'b0, e, "step_bkpt");
        return;
      end
      e.steps = 16'(n - k);
      junk_tick(1'b0, 1'b0, e, "step_cnt");
    end
  endtask

  // CORE_RESET; ret says whether the core comes back halted.
  task automatic rst_seq(input logic [StepW-1:0] cnt, input logic bk, input bit ret,
                         input int abort);
    obs_t e;
    e = settled();
    e.clk_en   = 1'b1;
    e.dm_reset = 1'b1;
    e.halted   = 1'b0;
    e.ready    = 1'b0;
    tick(1'b1, OpReset, cnt, bk, 1'b0, e, "rst_go");
    for (int k = 1; k <= int'(RstCycles); k++) begin
      if (k == abort) begin
        reset_tick();
        return;
      end
      if (k == int'(RstCycles)) begin
        m_steps = '0;
        m_halt  = ret;
        e = settled();
        e.done = 1'b1;
        junk_tick(1'($urandom % 2), 1'b0, e, "rst_end");
      end else begin
        junk_tick(1'($urandom % 2), 1'b0, e, "rst_hold");
      end
    end
  endtask

  task automatic cmd(input logic [1:0] op, input logic [StepW-1:0] cnt, input logic bk,
                     input int b, input int abort);
    obs_t e;
    if (!m_halt) begin
      if (bk) begin
        m_halt = 1'b1;
        m_flag = 1'b1;
        e = settled();
        e.done = 1'b1;
        tick(1'b1, op, cnt, 1'b1, 1'b0, e, "run_bkpt");
      end else begin
        case (op)
          OpHalt: begin
            m_halt = 1'b1;
            tick(1'b1, op, cnt, 1'b0, 1'b0, settled(), "run_halt");
          end
          OpReset: rst_seq(cnt, 1'b0, 1'b0, abort);
          default: tick(1'b1, op, cnt, 1'b0, 1'b0, settled(), "run_noop");
        endcase
      end
    end else begin
      case (op)
        OpHalt: tick(1'b1, op, cnt, bk, 1'b0, settled(), "halt_noop");
        OpResume: begin
          m_halt = 1'b0;
          m_flag = 1'b0;
          tick(1'b1, op, cnt, bk, 1'b0, settled(), "resume");
        end
        OpStep: step_seq(cnt, bk, b, abort);
        default: begin
          m_flag = 1'b0;
          rst_seq(cnt, bk, 1'b1, abort);
        end
      endcase
    end
  endtask

  // Monitor: every cycle, compare DUT outputs with the oldest expectation.
  initial begin
    obs_t  a;
    obs_t  e;
    string t;
    forever begin
      @(posedge sys_clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        a = {clk_en, dm_reset, halted, steps_left, bkpt_flag, done, cmd_ready};
        checks++;
        if (a === e) begin
          passes++;
        end else begin
          $display("FAIL %s @%0t: actual clk_en=%b dm_reset=%b halted=%b steps=%0d flag=%b done=%b ready=%b, required clk_en=%b dm_reset=%b halted=%b steps=%0d flag=%b done=%b ready=%b",
                   t, $time, a.clk_en, a.dm_reset, a.halted, a.steps, a.flag, a.done, a.ready,
                   e.clk_en, e.dm_reset, e.halted, e.steps, e.flag, e.done, e.ready);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

  initial begin
    int               n;
    logic [1:0]       op;
    logic [StepW-1:0] cnt;
    logic             bk;
    int               b;
    int               abort;

    reset_tick();
    reset_tick();

    // Directed scenarios.
    cmd(OpHalt, 16'd0, 1'b0, 0, 0);
    idle(2);
    cmd(OpStep, 16'd3, 1'b0, 0, 0);
    idle(1);
    cmd(OpStep, 16'd0, 1'b0, 0, 0);
    idle(1);
    cmd(OpStep, 16'd10, 1'b0, 4, 0);
    idle(1);
    cmd(OpResume, 16'd0, 1'b0, 0, 0);
    idle(2);
    cmd(OpHalt, 16'd0, 1'b0, 0, 0);
    cmd(OpReset, 16'd0, 1'b0, 0, 0);
    idle(1);
    cmd(OpResume, 16'd0, 1'b0, 0, 0);
    cmd(OpReset, 16'd0, 1'b0, 0, 0);
    idle(1);
    cmd(OpHalt, 16'd0, 1'b0, 0, 0);
    cmd(OpStep, 16'd8, 1'b0, 0, 4);
    idle(1);
    cmd(OpHalt, 16'd0, 1'b0, 0, 0);
    cmd(OpReset, 16'd0, 1'b0, 0, 3);
    idle(1);
    cmd(OpHalt, 16'd0, 1'b0, 0, 0);
    cmd(OpStep, 16'd5, 1'b0, 5, 0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      if ($urandom % 4 == 0) begin
        idle(int'($urandom_range(1, 3)));
      end else begin
        op    = 2'($urandom);
        cnt   = ($urandom % 5 == 0) ? 16'd0 : 16'($urandom_range(1, 12));
        n     = (cnt == '0) ? 1 : int'(cnt);
        bk    = m_halt ? 1'($urandom % 2) : 1'($urandom % 6 == 0);
        b     = int'($urandom_range(0, 14));
        abort = ($urandom % 15 == 0) ? int'($urandom_range(1, 10)) : 0;
        if (b > n) b = 0;
        cmd(op, cnt, bk, b, abort);
      end
    end

    idle(2);
    repeat (3) @(posedge sys_clk);
    #3;
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dbg_run_ctrl.md
# dbg_run_ctrl

Debug run-control sequencer in the `sys_clk` domain. It accepts single-beat halt, step-N, resume and core-reset commands from the debug module over a valid/ready handshake. It drives the clock-enable that feeds the external negedge clock-gate latch, and the core reset pulse. It also halts the core on a breakpoint request and reports halt status, remaining step count and completion.

## Interface
- `STEP_W`, 16: width of step count and `steps_left`.
- `RST_CYCLES`, 8: cycles `dm_reset` is held high per CORE_RESET; must be ≥1.

- `sys_clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command can be accepted; combinational from state.
- `cmd_op`  in  2  00 HALT, 01 STEP, 10 RESUME, 11 CORE_RESET.
- `cmd_count`  in  STEP_W  step count for STEP; 0 treated as 1.
- `bkpt_hit`  in  1  level halt request from breakpoint logic.
- `clk_en`  out  1  registered core clock enable, to external negedge gate latch.
- `dm_reset`  out  1  registered core reset.
- `halted`  out  1  high only in HALT state.
- `steps_left`  out  STEP_W  remaining step cycles.
- `bkpt_flag`  out  1  sticky: last halt was caused by `bkpt_hit`.
- `done`  out  1  one-cycle pulse on step completion, breakpoint halt or end of reset.

## Operation
- States: RUN, HALT, STEP, RSTHOLD. Plus a 1-bit `ret_halt` recording the state to return to after RSTHOLD.
- Accept happens when `cmd_valid && cmd_ready` at a rising edge. `cmd_ready` = 1 in RUN/HALT and 0 in STEP/RSTHOLD.
- RUN (`clk_en`=1):
  - `bkpt_hit` → HALT with `bkpt_flag`←1 and `done`←1. This has priority over a same-edge command; that command is still accepted and discarded.
  - HALT → HALT.
  - CORE_RESET → RSTHOLD with `ret_halt`←0.
  - STEP and RESUME are accepted no-ops.
- HALT (`clk_en`=0):
  - STEP → STEP with `steps_left`←max(`cmd_count`,1).
  - RESUME → RUN.
  - CORE_RESET → RSTHOLD with `ret_halt`←1.
  - HALT is a no-op.
  - `bkpt_hit` is ignored.
  - Accepted STEP, RESUME and CORE_RESET clear `bkpt_flag`.
- STEP (`clk_en`=1):
  - Each edge, `steps_left` decrements.
  - When `steps_left`==1 at an edge: → HALT, `steps_left`←0, `clk_en`←0, `done`←1.
  - Otherwise, `bkpt_hit` at an edge: → HALT, `steps_left` holds (not decremented), `bkpt_flag`←1, `done`←1.
  - `bkpt_hit` on the final-count edge counts as normal completion, with `bkpt_flag` unchanged.
- RSTHOLD (`clk_en`=1, `dm_reset`=1):
  - An internal counter runs `RST_CYCLES` cycles, then the block returns to HALT (`ret_halt`=1) or RUN.
  - On return: `dm_reset`←0, `done`←1, `steps_left`←0.
  - `bkpt_hit` is ignored.
- `steps_left` wraps never: decrement happens only in STEP while ≥1.

## Timing
- Reset (dominates all inputs, any state): state RUN, `clk_en`=1, `dm_reset`=0, `halted`=0, `steps_left`=0, `bkpt_flag`=0, `done`=0, counter 0. `cmd_ready`=1 the cycle after.
- All outputs except `cmd_ready` are registered and change at the accept/event edge; latency is 1 edge.
- STEP N accepted at edge E0:
  - `clk_en`=1 from after E0 until E_N; `clk_en`←0 at E_N, giving exactly N enabled cycles.
  - `steps_left` reads N, N-1, …, 1, then 0 at E_N.
  - `done`=1 for the single cycle after E_N.
  - `cmd_ready` low from after E0 until E_N.
- HALT accepted at edge E: `clk_en`=0 and `halted`=1 after E.
- CORE_RESET accepted at E0: `dm_reset`=1 for exactly `RST_CYCLES` cycles; `dm_reset`←0 at E_RST_CYCLES.
- `done` never asserts for two consecutive cycles from a single event.

## Test plan
- Reset, then HALT accepted: `clk_en` 1→0 one edge later, `halted`=1, `cmd_ready`=1.
- From HALT, STEP `cmd_count`=3: `clk_en` high exactly 3 cycles; `steps_left` reads 3,2,1,0; one `done` pulse; `halted`=1 after.
- From HALT, STEP count 0: exactly 1 enabled cycle; `done` once.
- STEP 10 with `bkpt_hit` pulsed at the 4th edge after accept: HALT, `steps_left`=7, `bkpt_flag`=1. A following RESUME clears `bkpt_flag` and sets `clk_en`=1.
- CORE_RESET from HALT with `RST_CYCLES`=8: `dm_reset` high 8 cycles with `clk_en`=1, then HALT with `clk_en`=0 and `done` pulse. From RUN, the block returns to RUN.
- `reset` asserted mid-STEP (`steps_left`=5) and mid-RSTHOLD: next cycle RUN, `clk_en`=1, `dm_reset`=0, `steps_left`=0.
